dclock_disp_scan: RTL and testbench

//  Downstream consumer of DATE (mon/day) and TIME (hour/min/sec). Converts the values to BCD
//  and time-multiplexes a 6-digit common-drive 7-segment display.

---
 rtl/dclock_disp_scan_pkg.sv | 55 +++++
 rtl/dclock_disp_scan_bin2bcd6.sv | 37 +++
 rtl/dclock_disp_scan.sv | 138 +++++++++++++
 tb/tb_dclock_disp_scan.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dclock_disp_scan_pkg.sv
// ----------------------------------------------------------------------------
// dclock_disp_scan_pkg
// Shared constants for the digital-clock display path:
//   - M1_* major modes and M2_* minor modes produced by MODE_GEN
//   - 7-segment codes {g,f,e,d,c,b,a}, active high, for digits 0..9 and blank
//   - NUM_DIGITS: number of multiplexed display digits
//   - seg_code(): decimal digit -> segment pattern (anything above 9 is blank)
// No ports (package).
// ----------------------------------------------------------------------------
package dclock_disp_scan_pkg;

  // Major modes
  localparam logic [1:0] M1_TIME  = 2'd0;
  localparam logic [1:0] M1_DATE  = 2'd1;
  localparam logic [1:0] M1_TIMER = 2'd2;
  localparam logic [1:0] M1_ALARM = 2'd3;

  // Minor modes inside M1_DATE
  localparam logic [1:0] M2_DATE_G   = 2'd0;
  localparam logic [1:0] M2_DATE_MON = 2'd1;
  localparam logic [1:0] M2_DATE_DAY = 2'd2;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int NUM_DIGITS = 6;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dclock_disp_scan_bin2bcd6.sv
// ----------------------------------------------------------------------------
// dclock_disp_scan_bin2bcd6
// Combinational 6-bit binary to two-digit BCD, built from compare-subtract
// steps (40, 20, 10) instead of a divider. Values 60..63 come out literally
// with tens = 6.
// Ports:
//   in   [5:0]  binary value 0..63
//   tens [2:0]  in / 10
//   ones [3:0]  in % 10
// ----------------------------------------------------------------------------
module dclock_disp_scan_bin2bcd6 (
  input  logic [5:0] in,
  output logic [2:0] tens,
  output logic [3:0] ones
);

  logic [5:0] r;

  always_comb begin
    r    = in;
    tens = 3'd0;
    if (r >= 6'd40) begin
      r    = r - 6'd40;
      tens = tens + 3'd4;
    end
    if (r >= 6'd20) begin
      r    = r - 6'd20;
      tens = tens + 3'd2;
    end
    if (r >= 6'd10) begin
      r    = r - 6'd10;
      tens = tens + 3'd1;
    end
    ones = r[3:0];
  end

endmodule

// File: rtl/dclock_disp_scan.sv
// ----------------------------------------------------------------------------
// dclock_disp_scan
// Time-multiplexes DATE (mon/day) or TIME (hour/min/sec) onto a 6-digit
// common-drive 7-segment display. Date is shown in M1_DATE, time otherwise.
// In M2_DATE_MON / M2_DATE_DAY the field being edited blinks.
// Parameters:
//   SCAN_DIV   clk cycles each digit stays selected (>=2)
//   BLINK_DIV  clk cycles per blink half-period (>=2)
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous reset, active low
//   mode1[1:0] major mode          mode2[1:0] minor mode
//   mon[3:0]   month 1..12         day[5:0]   day 1..31
//   hour[4:0]  hour 0..23          min[5:0]   minute 0..59
//   sec[5:0]   second 0..59
//   digit_en[5:0] one-hot digit select, bit0 = rightmost digit
//   seg[6:0]   segments {g,f,e,d,c,b,a}, active high
//   colon      colon LED, active high
// Outputs are registered: each edge drives the digit selected by digit_idx
// during the cycle before it, together with that digit's pattern computed
// from the inputs of that same cycle.
// ----------------------------------------------------------------------------
module dclock_disp_scan
  import dclock_disp_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 250000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] mode1,
  input  logic [1:0] mode2,
  input  logic [3:0] mon,
  input  logic [5:0] day,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  output logic [5:0] digit_en,
  output logic [6:0] seg,
  output logic       colon
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIGITS - 1);

  logic [SW-1:0] scan_cnt;
  logic [2:0]    digit_idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;
  logic [3:0]    mode_q;

  logic          date_mode;
  logic          mode_chg;
  logic          blink_vis;
  logic [5:0]    pair_val;
  logic [2:0]    tens;
  logic [3:0]    ones;
  logic [3:0]    digit_val;
  logic          blank;
  logic [6:0]    seg_next;

  assign date_mode = (mode1 == M1_DATE);
  assign mode_chg  = ({mode1, mode2} != mode_q);
  // A fresh mode entry forces the field visible in the very cycle it happens,
  // before blink_on has been reloaded.
  assign blink_vis = blink_on | mode_chg;

  // Value for the digit pair under the scan: pair 0 = d1:d0, 1 = d3:d2, 2 = d5:d4.
  always_comb begin
    pair_val = 6'd0;
    case (digit_idx[2:1])
      2'd0:    pair_val = date_mode ? day : sec;
      2'd1:    pair_val = date_mode ? {2'b00, mon} : min;
      default: pair_val = date_mode ? 6'd0 : {1'b0, hour};
    endcase
  end

  dclock_disp_scan_bin2bcd6 u_bcd (
    .in   (pair_val),
    .tens (tens),
    .ones (ones)
  );

  // Odd digits carry the tens, even digits the ones.
  assign digit_val = digit_idx[0] ? {1'b0, tens} : ones;

  always_comb begin
    blank = 1'b0;
    if (date_mode) begin
      if (digit_idx[2:1] == 2'd2)
        blank = 1'b1;
      if ((mode2 == M2_DATE_MON) && !blink_vis && (digit_idx[2:1] == 2'd1))
        blank = 1'b1;
      if ((mode2 == M2_DATE_DAY) && !blink_vis && (digit_idx[2:1] == 2'd0))
        blank = 1'b1;
    end
    seg_next = blank ? SEG_BLANK : seg_code(digit_val);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt  <= '0;
      digit_idx <= 3'd0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      mode_q    <= 4'd0;
      digit_en  <= 6'd0;
      seg       <= 7'd0;
      colon     <= 1'b0;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt  <= '0;
        digit_idx <= (digit_idx == IDX_LAST) ? 3'd0 : digit_idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      if (mode_chg) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      mode_q   <= {mode1, mode2};
      digit_en <= 6'b000001 << digit_idx;
      seg      <= seg_next;
      colon    <= ~date_mode;
    end
  end

endmodule

// File: tb/tb_dclock_disp_scan.sv
// ----------------------------------------------------------------------------
// tb_dclock_disp_scan
// Directed steps plus randomized traffic for dclock_disp_scan with
// SCAN_DIV=2, BLINK_DIV=4. The reference model works cycle by cycle from the
// number of cycles since reset release and since the last mode change, using
// plain division/modulo for scan position, blink phase and BCD digits.
// ----------------------------------------------------------------------------
module tb_dclock_disp_scan;
  import dclock_disp_scan_pkg::*;

  localparam int SDIV = 2;
  localparam int BDIV = 4;

  // clock / reset
  logic       clk;
  logic       reset_n;
  logic [1:0] mode1, mode2;
  logic [3:0] mon;
  logic [5:0] day, min, sec;
  logic [4:0] hour;
  logic [5:0] digit_en;
  logic [6:0] seg;
  logic       colon;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dclock_disp_scan #(.SCAN_DIV(SDIV), .BLINK_DIV(BDIV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .mode1    (mode1),
    .mode2    (mode2),
    .mon      (mon),
    .day      (day),
    .hour     (hour),
    .min      (min),
    .sec      (sec),
    .digit_en (digit_en),
    .seg      (seg),
    .colon    (colon)
  );

  // scoreboard
  logic [13:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // model state
  int         m_j;          // cycles since reset release
  int         m_last_chg;   // cycle of last mode change (-1 = reset)
  logic [3:0] m_prev_mode;  // mode seen last cycle (reset value 0)
  bit         m_vis;        // edited field visible this cycle
  logic [6:0] seg_tab[10];
  logic [6:0] seen[6];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_j         = 0;
    m_last_chg  = -1;
    m_prev_mode = 4'd0;
    m_vis       = 1'b1;
    exp_q.delete();
  endtask

  function automatic logic [13:0] model_expect();
    int   idx, pair, v, d;
    bit   date, chg, blank;
    logic [6:0] s;
    logic [5:0] de;
    idx  = (m_j / SDIV) % 6;
    pair = idx / 2;
    date = (mode1 == M1_DATE);
    chg  = ({mode1, mode2} != m_prev_mode);
    if (chg) m_last_chg = m_j;
    m_vis = chg || ((((m_j - m_last_chg - 1) / BDIV) % 2) == 0);
    if (date) v = (pair == 0) ? int'(day) : (pair == 1) ? int'(mon) : 0;
    else      v = (pair == 0) ? int'(sec) : (pair == 1) ? int'(min) : int'(hour);
    d = (idx % 2 == 1) ? v / 10 : v % 10;
    blank = (date && pair == 2) ||
            (date && mode2 == M2_DATE_MON && !m_vis && pair == 1) ||
            (date && mode2 == M2_DATE_DAY && !m_vis && pair == 0);
    s  = blank ? 7'h00 : seg_tab[d];
    de = 6'(1 << idx);
    return {de, s, ~date};
  endfunction

  // driver: one clock cycle with the currently driven inputs, then check
  task automatic run_cycle();
    logic [13:0] e;
    exp_q.push_back(model_expect());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("digit_en", {2'b0, digit_en}, {2'b0, e[13:8]});
    chk("seg", {1'b0, seg}, {1'b0, e[7:1]});
    chk("colon", {7'b0, colon}, {7'b0, e[0]});
    for (int b = 0; b < 6; b++)
      if (digit_en[b]) seen[b] = seg;
    m_prev_mode = {mode1, mode2};
    m_j++;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_digit_en"}, {2'b0, digit_en}, 8'h00);
    chk({tag, "_seg"}, {1'b0, seg}, 8'h00);
    chk({tag, "_colon"}, {7'b0, colon}, 8'h00);
  endtask

  task automatic check_seen(input string tag, input logic [6:0] e5, input logic [6:0] e4,
                            input logic [6:0] e3, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] ex[6];
    ex[5] = e5; ex[4] = e4; ex[3] = e3; ex[2] = e2; ex[1] = e1; ex[0] = e0;
    for (int b = 0; b < 6; b++)
      chk($sformatf("%s_d%0d", tag, b), {1'b0, seen[b]}, {1'b0, ex[b]});
  endtask

  initial begin
    int guard;
    seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
    seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
    seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;

    // 1: reset held, then released
    reset_n = 1'b0;
    mode1 = M1_TIME; mode2 = M2_DATE_G;
    mon = 4'd1; day = 6'd1; hour = 5'd12; min = 6'd34; sec = 6'd56;
    #1;
    check_zero("rst_t0");
    repeat (3) begin
      @(posedge clk); #1;
      check_zero("rst_hold");
    end
    reset_n = 1'b1;
    model_reset();
    run_cycle();
    chk("first_edge_en", {2'b0, digit_en}, 8'h01);
    run_cycle();
    run_cycle();
    chk("third_edge_en", {2'b0, digit_en}, 8'h02);

    // 2: free-run walk, with the model checking every edge
    repeat (12) run_cycle();

    // 3: date mode, general submode, 01/01
    mode1 = M1_DATE; mode2 = M2_DATE_G; mon = 4'd1; day = 6'd1;
    for (int b = 0; b < 6; b++) seen[b] = 7'h7F;
    repeat (12) run_cycle();
    check_seen("date_0101", 7'h00, 7'h00, 7'h3F, 7'h06, 7'h3F, 7'h06);
    chk("date_colon", {7'b0, colon}, 8'h00);

    // 4: time mode 23:59:58
    mode1 = M1_TIME; mode2 = M2_DATE_G; hour = 5'd23; min = 6'd59; sec = 6'd58;
    for (int b = 0; b < 6; b++) seen[b] = 7'h00;
    repeat (12) run_cycle();
    check_seen("time_235958", 7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h6D, 7'h7F);
    chk("time_colon", {7'b0, colon}, 8'h01);

    // 5: month blink at 12/31, then switch to day edit while month is blank
    mode1 = M1_DATE; mode2 = M2_DATE_MON; mon = 4'd12; day = 6'd31;
    repeat (20) run_cycle();
    guard = 0;
    while (m_vis && guard < 20) begin
      run_cycle();
      guard++;
    end
    chk("blank_phase_reached", {7'b0, m_vis}, 8'h00);
    mode2 = M2_DATE_DAY;
    repeat (24) run_cycle();

    // 6: reset while digit 3 is being driven in time mode
    mode1 = M1_TIME; mode2 = M2_DATE_G;
    guard = 0;
    while (((m_j / SDIV) % 6) != 3 && guard < 20) begin
      run_cycle();
      guard++;
    end
    chk("reached_digit3", 8'((m_j / SDIV) % 6), 8'd3);
    reset_n = 1'b0;
    #1;
    check_zero("rst_mid");
    @(posedge clk); #1;
    check_zero("rst_mid_hold");
    reset_n = 1'b1;
    model_reset();
    run_cycle();
    chk("restart_en", {2'b0, digit_en}, 8'h01);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        mode1 = 2'($urandom_range(0, 3));
        mode2 = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) == 0) begin
        mon  = 4'($urandom_range(1, 12));
        day  = 6'($urandom_range(1, 31));
        hour = 5'($urandom_range(0, 23));
        min  = 6'($urandom_range(0, 63));
        sec  = 6'($urandom_range(0, 63));
      end
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
